wrap_counter: RTL and testbench



---
 rtl/wrap_counter.sv | 72 +++++++
 tb/tb_wrap_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
//
// Purpose:
//   Parameterised binary up-counter with count enable and a registered wrap
//   flag. The count runs 0 .. 2^WIDTH-1 and wraps back to 0. The wrap flag is
//   taken straight from a flop so it can safely clock a downstream instance,
//   which lets several instances be chained as a ripple prescaler.
//
// Parameters:
//   WIDTH     counter width in bits, 1..32 (terminal count = 2^WIDTH-1)
//
// Ports:
//   clk       in   1      single clock, all state changes on the rising edge
//   rst       in   1      asynchronous active-low reset; clears out/overflow at
//                         once, release is seen at the next rising clk
//   en        in   1      count enable, sampled on rising clk
//   out       out  WIDTH  current count, registered
//   overflow  out  1      one-clock pulse in the cycle right after a wrap,
//                         registered (no decode on the output path)
// -----------------------------------------------------------------------------
module wrap_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] TERMINAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;

    // Next-state logic. The wrap flag is recomputed every edge and defaults
    // low, so a stalled cycle (en=0) always drops it even when the count is
    // parked at the terminal value.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (en) begin
            if (count_q == TERMINAL) begin
                count_d = '0;
                ovf_d   = 1'b1;
            end else begin
                // Carry out of the MSB is discarded by the fixed width.
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Both outputs are bare flop outputs; overflow must stay glitch-free
    // because it may be used as a clock downstream.
    assign out      = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_wrap_counter.sv
// -----------------------------------------------------------------------------
// tb_wrap_counter
//
// Three instances share rst and en:
//   u3 : WIDTH=3, clocked by clk
//   u2 : WIDTH=2, clocked by u3.overflow (ripple cascade)
//   u1 : WIDTH=1, clocked by clk
// Inputs change and outputs are sampled 2 time units after each rising clk.
// -----------------------------------------------------------------------------
module tb_wrap_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] out3;
    logic       ovf3;
    logic [1:0] out2;
    logic       ovf2;
    logic [0:0] out1;
    logic       ovf1;

    int n_pass;
    int n_total;

    wrap_counter #(.WIDTH(3)) u3 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .out      (out3),
        .overflow (ovf3)
    );

    wrap_counter #(.WIDTH(2)) u2 (
        .clk      (ovf3),
        .rst      (rst),
        .en       (en),
        .out      (out2),
        .overflow (ovf2)
    );

    wrap_counter #(.WIDTH(1)) u1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .out      (out1),
        .overflow (ovf1)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle into the sampling point.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        // Reset held with en=1 while the clock runs.
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_out3", 32'(out3), 32'd0);
            chk("rst_hold_ovf3", 32'(ovf3), 32'd0);
            chk("rst_hold_out2", 32'(out2), 32'd0);
            chk("rst_hold_out1", 32'(out1), 32'd0);
        end

        // Release reset with en=0: nothing moves.
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("release_out3", 32'(out3), 32'd0);
        tick();
        chk("release_noen_out3", 32'(out3), 32'd0);
        chk("release_noen_ovf3", 32'(ovf3), 32'd0);

        // Count up to 5.
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("count_out3", 32'(out3), 32'(i));
            chk("count_ovf3", 32'(ovf3), 32'd0);
        end

        // Stall at 5 for 4 clocks.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall5_out3", 32'(out3), 32'd5);
            chk("stall5_ovf3", 32'(ovf3), 32'd0);
        end

        en = 1'b1;
        tick();
        chk("resume_out3_6", 32'(out3), 32'd6);
        tick();
        chk("resume_out3_7", 32'(out3), 32'd7);
        chk("resume_ovf3_7", 32'(ovf3), 32'd0);

        // Stall at the terminal count: no overflow while parked.
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall7_out3", 32'(out3), 32'd7);
            chk("stall7_ovf3", 32'(ovf3), 32'd0);
        end

        // Re-enable: wrap to 0 with a single overflow pulse; u2 steps once.
        en = 1'b1;
        tick();
        chk("wrap_out3", 32'(out3), 32'd0);
        chk("wrap_ovf3", 32'(ovf3), 32'd1);
        chk("wrap_out2", 32'(out2), 32'd1);
        tick();
        chk("after_wrap_out3", 32'(out3), 32'd1);
        chk("after_wrap_ovf3", 32'(ovf3), 32'd0);

        for (int i = 2; i <= 7; i++) begin
            tick();
            chk("climb_out3", 32'(out3), 32'(i));
        end

        // Async reset between edges while out3 == 7.
        rst = 1'b0;
        #1;
        chk("async_at7_out3", 32'(out3), 32'd0);
        chk("async_at7_ovf3", 32'(ovf3), 32'd0);
        chk("async_at7_out2", 32'(out2), 32'd0);

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_hold2_out3", 32'(out3), 32'd0);
        end

        // Full count plus cascade, en=1 for 40 clocks.
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("full_out3", 32'(out3), 32'(i % 8));
            chk("full_ovf3", 32'(ovf3), 32'((i % 8) == 0));
            chk("casc_out2", 32'(out2), 32'((i / 8) % 4));
            chk("casc_ovf2", 32'(ovf2), 32'(i >= 32 && i < 40));
            chk("w1_out1", 32'(out1), 32'(i % 2));
            chk("w1_ovf1", 32'(ovf1), 32'((i % 2) == 0));
        end

        // Async reset while an overflow pulse is high.
        chk("pre_rst_ovf3", 32'(ovf3), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_ovf_ovf3", 32'(ovf3), 32'd0);
        chk("async_ovf_out3", 32'(out3), 32'd0);
        chk("async_ovf_out2", 32'(out2), 32'd0);
        chk("async_ovf_ovf2", 32'(ovf2), 32'd0);
        chk("async_ovf_out1", 32'(out1), 32'd0);
        chk("async_ovf_ovf1", 32'(ovf1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
